operand_bypass_pipe: RTL

//  Decode-to-execute operand stage with a valid/ready output register. It takes a decoded

---
 rtl/operand_bypass_pipe_pkg.sv | 15 +
 rtl/operand_bypass_pipe_if.sv | 38 +++
 rtl/operand_bypass_pipe_bypass_select.sv | 33 +++
 rtl/operand_bypass_pipe.sv | 89 ++++++++
 4 files changed

// File: rtl/operand_bypass_pipe_pkg.sv
// Shared frontend definitions: logical register width and the bypass channel record
// used to hand producer state to the per-operand selectors.
package frontend_pkg;

  localparam int LREG_W     = 5;
  localparam int BYP_DATA_W = 64;

  typedef struct packed {
    logic                  valid;
    logic                  data_ok;
    logic [LREG_W-1:0]     rd;
    logic [BYP_DATA_W-1:0] data;
  } byp_chan_t;

endpackage

// File: rtl/operand_bypass_pipe_if.sv
// Decode-side request and execute-side response bundle of the operand stage.
// master = decode/execute neighbours, slave = the operand stage itself.
interface operand_bypass_pipe_if
  import frontend_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int PAYLOAD_W = 128
) ();

  logic                 dec_valid;
  logic                 dec_ready;
  logic [LREG_W-1:0]    dec_rs1;
  logic [LREG_W-1:0]    dec_rs2;
  logic                 dec_src1_is_reg;
  logic                 dec_src2_is_reg;
  logic [XLEN-1:0]      dec_src1_raw;
  logic [XLEN-1:0]      dec_src2_raw;
  logic [PAYLOAD_W-1:0] dec_payload;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_src1;
  logic [XLEN-1:0]      out_src2;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_src1_is_reg, dec_src2_is_reg,
           dec_src1_raw, dec_src2_raw, dec_payload, out_ready,
    input  dec_ready, out_valid, out_src1, out_src2, out_payload
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_src1_is_reg, dec_src2_is_reg,
           dec_src1_raw, dec_src2_raw, dec_payload, out_ready,
    output dec_ready, out_valid, out_src1, out_src2, out_payload
  );

endinterface

// File: rtl/operand_bypass_pipe_bypass_select.sv
// Per-operand forwarding selector: youngest matching producer wins and, if its
// result is still outstanding, raises a hazard for that operand.
module bypass_select
  import frontend_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_BYP = 3
) (
  input  logic [LREG_W-1:0] rs,
  input  logic              is_reg,
  input  logic [XLEN-1:0]   raw,
  input  byp_chan_t         chans [NUM_BYP],
  output logic [XLEN-1:0]   value,
  output logic              hazard
);

  logic found;

  // x0 is hardwired, so it never matches a producer even if one targets it.
  always_comb begin
    value  = raw;
    hazard = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < NUM_BYP; i++) begin
      if (!found && is_reg && (rs != '0) && chans[i].valid && (chans[i].rd == rs)) begin
        found  = 1'b1;
        value  = XLEN'(chans[i].data);
        hazard = ~chans[i].data_ok;
      end
    end
  end

endmodule

// File: rtl/operand_bypass_pipe.sv
// Decode-to-execute operand stage: N-channel bypass, load-use interlock, flush,
// valid/ready output register and a saturating stall counter.
module operand_bypass_pipe
  import frontend_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int NUM_BYP   = 3,
  parameter int PAYLOAD_W = 128,
  parameter int CNT_W     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  operand_bypass_pipe_if.slave      pipe,
  input  logic [NUM_BYP-1:0]        byp_valid,
  input  logic [NUM_BYP-1:0]        byp_data_ok,
  input  logic [NUM_BYP*LREG_W-1:0] byp_rd,
  input  logic [NUM_BYP*XLEN-1:0]   byp_data,
  input  logic                      flush_valid,
  output logic                      hazard_stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  byp_chan_t            chans [NUM_BYP];
  logic [XLEN-1:0]      sel1, sel2;
  logic                 haz1, haz2;
  logic                 ready, accept;
  logic                 out_valid_q;
  logic [XLEN-1:0]      src1_q, src2_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [CNT_W-1:0]     cnt_q;

  always_comb begin
    for (int i = 0; i < NUM_BYP; i++) begin
      chans[i].valid   = byp_valid[i];
      chans[i].data_ok = byp_data_ok[i];
      chans[i].rd      = byp_rd[LREG_W*i +: LREG_W];
      chans[i].data    = BYP_DATA_W'(byp_data[XLEN*i +: XLEN]);
    end
  end

  bypass_select #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_sel1 (
    .rs(pipe.dec_rs1), .is_reg(pipe.dec_src1_is_reg), .raw(pipe.dec_src1_raw),
    .chans(chans), .value(sel1), .hazard(haz1)
  );

  bypass_select #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_sel2 (
    .rs(pipe.dec_rs2), .is_reg(pipe.dec_src2_is_reg), .raw(pipe.dec_src2_raw),
    .chans(chans), .value(sel2), .hazard(haz2)
  );

  // No skid buffer: readiness looks straight through to the execute-side ready.
  assign hazard_stall = pipe.dec_valid & (haz1 | haz2) & ~flush_valid;
  assign ready        = ~flush_valid & ~hazard_stall & (~out_valid_q | pipe.out_ready);
  assign accept       = pipe.dec_valid & ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      payload_q   <= '0;
    end else if (flush_valid) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      src1_q      <= sel1;
      src2_q      <= sel2;
      payload_q   <= pipe.dec_payload;
    end else if (pipe.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (hazard_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pipe.dec_ready   = ready;
  assign pipe.out_valid   = out_valid_q;
  assign pipe.out_src1    = src1_q;
  assign pipe.out_src2    = src2_q;
  assign pipe.out_payload = payload_q;
  assign stall_cnt        = cnt_q;

endmodule
